// File: rtl/fifo_buffer_pkg.sv
// Shared constants, helper functions and the operation encoding for the FWFT FIFO.
// Imported by the interface, the storage array and the FIFO control logic.
package fifo_buffer_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_DEPTH = 4;

    // Single bit replicated to WIDTH to form the out_data value shown while empty.
    localparam logic OUT_DATA_RST_BIT = 1'b0;

    // Encoding is {push, pop} so the handshake bits cast directly onto it.
    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_BOTH = 2'b11
    } fifo_op_e;

    function automatic int fifo_aw(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/fifo_buffer_if.sv
// Producer/consumer handshake bundle for fifo_buffer, including occupancy monitoring.
// The master modport is the environment side; the slave modport is the FIFO.
interface fifo_buffer_if #(
    parameter int WIDTH = 8,
    parameter int AW    = 2
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [AW:0]      count;
    logic             full;
    logic             empty;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  count,
        input  full,
        input  empty
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output count,
        output full,
        output empty
    );
endinterface

// File: rtl/fifo_buffer_ram.sv
// DEPTH x WIDTH register array: synchronous write, asynchronous read, contents never reset.
module fifo_buffer_ram #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_r [DEPTH];

    // Write port: only an accepted word touches the array.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/fifo_buffer.sv
// First-word-fall-through FIFO: pointer, occupancy and flag control around fifo_buffer_ram.
// Flags are registered alongside count so in_ready/out_valid depend only on state.
module fifo_buffer
    import fifo_buffer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int AW    = fifo_aw(DEPTH)
) (
    input logic           clk,
    input logic           rst_n,
    fifo_buffer_if.slave  bus
);

    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] ZERO_CNT  = {(AW+1){1'b0}};
    localparam logic [AW:0] ONE_CNT   = (AW+1)'(1);

    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic             full_r;
    logic             empty_r;
    logic             push_s;
    logic             pop_s;
    fifo_op_e         op_s;
    logic [AW:0]      count_next_s;
    logic [WIDTH-1:0] rdata_s;

    assign push_s = bus.in_valid & ~full_r;
    assign pop_s  = bus.out_ready & ~empty_r;
    assign op_s   = fifo_op_e'({push_s, pop_s});

    // Occupancy: a simultaneous push and pop leaves the count unchanged.
    always_comb begin
        count_next_s = count_r;
        case (op_s)
            OP_PUSH: count_next_s = count_r + ONE_CNT;
            OP_POP:  count_next_s = count_r - ONE_CNT;
            OP_BOTH: count_next_s = count_r;
            OP_IDLE: count_next_s = count_r;
            default: count_next_s = count_r;
        endcase
    end

    // Pointer, count and flag state; pointers wrap by natural AW-bit rollover.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= ZERO_CNT;
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            count_r <= count_next_s;
            full_r  <= (count_next_s == DEPTH_CNT);
            empty_r <= (count_next_s == ZERO_CNT);
        end
    end

    fifo_buffer_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (push_s),
        .waddr (wr_ptr_r),
        .wdata (bus.in_data),
        .raddr (rd_ptr_r),
        .rdata (rdata_s)
    );

    // Stale or never-written array contents are masked whenever the queue is empty.
    assign bus.out_data  = empty_r ? {WIDTH{OUT_DATA_RST_BIT}} : rdata_s;
    assign bus.in_ready  = ~full_r;
    assign bus.out_valid = ~empty_r;
    assign bus.count     = count_r;
    assign bus.full      = full_r;
    assign bus.empty     = empty_r;

endmodule

// File: tb/tb_fifo_buffer.sv
// Directed self-checking bench for fifo_buffer (WIDTH=8, DEPTH=4).
module tb_fifo_buffer;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    fifo_buffer_if #(.WIDTH(8), .AW(2)) bus ();

    fifo_buffer #(
        .WIDTH (8),
        .DEPTH (4),
        .AW    (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Rising edges at 10, 20, 30 ... so t=15 falls on a falling edge.
    initial begin
        clk = 1'b1;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.out_ready = 1'b0;

        // Reset state
        #15 rst_n = 1'b1;
        #1;
        chk("rst_empty",     32'(bus.empty),     32'd1);
        chk("rst_full",      32'(bus.full),      32'd0);
        chk("rst_count",     32'(bus.count),     32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
        chk("rst_out_data",  32'(bus.out_data),  32'h00);

        // Fill A1..A4
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 8'hA1 + 8'(i);
            tick();
            chk("fill_count", 32'(bus.count), 32'(i + 1));
            chk("fill_head",  32'(bus.out_data), 32'hA1);
        end
        chk("fill_full",     32'(bus.full),     32'd1);
        chk("fill_in_ready", 32'(bus.in_ready), 32'd0);
        bus.in_data = 8'hFF;
        tick();
        tick();
        chk("held_count", 32'(bus.count),    32'd4);
        chk("held_head",  32'(bus.out_data), 32'hA1);
        bus.in_valid = 1'b0;

        // Drain in order, then pop on empty
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("drain_valid", 32'(bus.out_valid), 32'd1);
            chk("drain_data",  32'(bus.out_data),  32'(8'hA1 + 8'(i)));
            tick();
            chk("drain_count", 32'(bus.count), 32'(3 - i));
        end
        chk("drain_empty",     32'(bus.empty),     32'd1);
        chk("drain_out_data",  32'(bus.out_data),  32'h00);
        chk("drain_out_valid", 32'(bus.out_valid), 32'd0);
        bus.in_data = 8'hxx;
        tick();
        chk("empty_pop_count", 32'(bus.count),    32'd0);
        chk("empty_pop_empty", 32'(bus.empty),    32'd1);
        chk("x_in_data_out",   32'(bus.out_data), 32'h00);
        bus.out_ready = 1'b0;

        // Simultaneous push/pop at count=2
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hB0;
        tick();
        chk("empty_push_valid", 32'(bus.out_valid), 32'd1);
        chk("empty_push_count", 32'(bus.count),     32'd1);
        bus.in_data = 8'hB1;
        tick();
        chk("sim_pre_head", 32'(bus.out_data), 32'hB0);
        bus.in_data   = 8'hC0;
        bus.out_ready = 1'b1;
        tick();
        chk("sim_count", 32'(bus.count),    32'd2);
        chk("sim_head",  32'(bus.out_data), 32'hB1);
        bus.in_valid = 1'b0;
        tick();
        chk("sim_next", 32'(bus.out_data), 32'hC0);
        chk("sim_cnt1", 32'(bus.count),    32'd1);

        // One entry with push and pop together
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hD1;
        tick();
        chk("one_count", 32'(bus.count),    32'd1);
        chk("one_head",  32'(bus.out_data), 32'hD1);
        bus.in_valid = 1'b0;
        tick();
        chk("one_empty", 32'(bus.empty), 32'd1);
        bus.out_ready = 1'b0;

        // Full with pop: no same-cycle write
        bus.in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.in_data = 8'hE0 + 8'(i);
            tick();
        end
        chk("e_full", 32'(bus.full), 32'd1);
        bus.in_data   = 8'hEE;
        bus.out_ready = 1'b1;
        tick();
        chk("fullpop_count",    32'(bus.count),    32'd3);
        chk("fullpop_in_ready", 32'(bus.in_ready), 32'd1);
        chk("fullpop_head",     32'(bus.out_data), 32'hE1);
        tick();
        chk("fullpop2_count", 32'(bus.count),    32'd3);
        chk("fullpop2_head",  32'(bus.out_data), 32'hE2);
        bus.in_valid = 1'b0;
        tick();
        chk("e_tail_e3", 32'(bus.out_data), 32'hE3);
        tick();
        chk("e_tail_ee", 32'(bus.out_data), 32'hEE);
        tick();
        chk("e_tail_empty", 32'(bus.empty), 32'd1);

        // Wrap-around: stream 00..09 with concurrent pops
        bus.in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus.in_data = 8'(i);
            if (i > 0) chk("wrap_head", 32'(bus.out_data), 32'(i - 1));
            tick();
            chk("wrap_count", 32'(bus.count), 32'd1);
        end
        bus.in_valid = 1'b0;
        chk("wrap_last", 32'(bus.out_data), 32'h09);
        tick();
        chk("wrap_empty", 32'(bus.empty), 32'd1);
        bus.out_ready = 1'b0;

        // Async reset mid-stream with count=3
        bus.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.in_data = 8'hF0 + 8'(i);
            tick();
        end
        bus.in_valid = 1'b0;
        chk("pre_rst_count", 32'(bus.count), 32'd3);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_count",     32'(bus.count),     32'd0);
        chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("arst_out_data",  32'(bus.out_data),  32'h00);
        #1 rst_n = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h5A;
        tick();
        bus.in_valid = 1'b0;
        chk("post_rst_count", 32'(bus.count),    32'd1);
        chk("post_rst_head",  32'(bus.out_data), 32'h5A);
        bus.out_ready = 1'b1;
        tick();
        chk("post_rst_empty", 32'(bus.empty),    32'd1);
        chk("post_rst_data",  32'(bus.out_data), 32'h00);
        bus.out_ready = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
